// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery multiplier result collector:
// default geometry, FSM state encoding and the word-index width helper.
package mm_pkg;

    localparam int W_DEF = 3;
    localparam int E_DEF = 2;
    localparam int N_DEF = W_DEF * E_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // A single-word operand still needs a one-bit counter to stay legal.
    function automatic int idx_w(input int e);
        return (e > 1) ? $clog2(e) : 1;
    endfunction

endpackage

// File: rtl/mm_word_addsub.sv
// One word slice: resolves a carry-save pair into binary with carry,
// then subtracts the matching modulus word with borrow.
module mm_word_addsub #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic [W-1:0] m,
    input  logic         bi,
    output logic [W-1:0] s,
    output logic         co,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s    = sum[W-1:0];
    assign co   = sum[W];
    // The extra top bit wraps to 1 exactly when the subtraction borrows.
    assign diff = {1'b0, s} - {1'b0, m} - {{W{1'b0}}, bi};
    assign d    = diff[W-1:0];
    assign bo   = diff[W];

endmodule

// File: rtl/mm_result_collector.sv
// Collects carry-save result words LSW-first, resolves S and D = S-M word-serially,
// then streams out R = (S >= M) ? D : S one word per handshake.
module mm_result_collector
    import mm_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int E = E_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic [W*E-1:0] m_vec,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   s0_word,
    input  logic [W-1:0]   s1_word,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_word,
    output logic           out_last,
    output logic           busy
);

    localparam int IDX_W = idx_w(E);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(E - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             ca, bw, sel_d;
    logic [W-1:0]     s_arr [E];
    logic [W-1:0]     d_arr [E];

    logic             accept, handshake, at_last;
    logic [W-1:0]     m_word, s_new, d_new;
    logic             ca_new, bw_new, ca_in, bw_in;

    assign in_ready  = rst_n && (state != EMIT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == EMIT);
    assign handshake = out_valid && out_ready;
    assign at_last   = (cnt == LAST);
    assign out_last  = out_valid && at_last;
    assign busy      = (state != IDLE);
    assign out_word  = out_valid ? (sel_d ? d_arr[cnt] : s_arr[cnt]) : '0;

    // Chain state is forced clear on word 0 so a stale carry can never leak in.
    assign ca_in = (cnt == '0) ? 1'b0 : ca;
    assign bw_in = (cnt == '0) ? 1'b0 : bw;

    always_comb begin
        m_word = '0;
        for (int i = 0; i < E; i++) begin
            if (cnt == IDX_W'(i)) m_word = m_vec[i*W +: W];
        end
    end

    mm_word_addsub #(.W(W)) u_addsub (
        .a  (s0_word),
        .b  (s1_word),
        .ci (ca_in),
        .m  (m_word),
        .bi (bw_in),
        .s  (s_new),
        .co (ca_new),
        .d  (d_new),
        .bo (bw_new)
    );

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: if (accept) state_nxt = at_last ? EMIT : ACCUM;
                EMIT:        if (handshake && at_last) state_nxt = IDLE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ca    <= 1'b0;
            bw    <= 1'b0;
            sel_d <= 1'b0;
            for (int i = 0; i < E; i++) begin
                s_arr[i] <= '0;
                d_arr[i] <= '0;
            end
        end else if (flush) begin
            cnt <= '0;
            ca  <= 1'b0;
            bw  <= 1'b0;
        end else if (accept) begin
            s_arr[cnt] <= s_new;
            d_arr[cnt] <= d_new;
            if (at_last) begin
                // Carry out of bit N means S >= 2^N > M, so D is the answer regardless of borrow.
                sel_d <= ca_new | ~bw_new;
                cnt   <= '0;
                ca    <= 1'b0;
                bw    <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                ca  <= ca_new;
                bw  <= bw_new;
            end
        end else if (handshake) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector with W=3, E=2, M=43.
module tb_mm_result_collector;

    localparam int W = 3;
    localparam int E = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic [W*E-1:0] m_vec = 6'd43;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   s0_word = '0;
    logic [W-1:0]   s1_word = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_word;
    logic           out_last;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] s0v;
        logic [5:0] s1v;
        logic [5:0] expv;
        string      tag;
    } vec_t;

    vec_t vecs [4];

    mm_result_collector #(.W(W), .E(E)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .m_vec     (m_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0_word   (s0_word),
        .s1_word   (s1_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        s0_word  = a;
        s1_word  = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Sends both words, then drains the result with out_ready held high.
    task automatic run_packet(input logic [5:0] s0v, input logic [5:0] s1v,
                              input logic [5:0] expv, input string tag);
        check({tag, "_in_ready_start"}, int'(in_ready), 1);
        send_word(s0v[2:0], s1v[2:0]);
        check({tag, "_busy_accum"}, int'(busy), 1);
        check({tag, "_out_valid_accum"}, int'(out_valid), 0);
        send_word(s0v[5:3], s1v[5:3]);
        check({tag, "_out_valid_w0"}, int'(out_valid), 1);
        check({tag, "_in_ready_emit"}, int'(in_ready), 0);
        check({tag, "_word0"}, int'(out_word), int'(expv[2:0]));
        check({tag, "_last0"}, int'(out_last), 0);
        out_ready = 1'b1;
        tick();
        check({tag, "_word1"}, int'(out_word), int'(expv[5:3]));
        check({tag, "_last1"}, int'(out_last), 1);
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_done"}, int'(out_valid), 0);
        check({tag, "_in_ready_done"}, int'(in_ready), 1);
        check({tag, "_busy_done"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{s0v: 6'd20, s1v: 6'd10, expv: 6'd30, tag: "s30"};
        vecs[1] = '{s0v: 6'd40, s1v: 6'd20, expv: 6'd17, tag: "s60"};
        vecs[2] = '{s0v: 6'd63, s1v: 6'd20, expv: 6'd40, tag: "s83"};
        vecs[3] = '{s0v: 6'd43, s1v: 6'd0,  expv: 6'd0,  tag: "s43eq"};

        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_word", int'(out_word), 0);
        check("rst_out_last", int'(out_last), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        tick();

        // Table-driven packets, back to back
        for (int i = 0; i < 4; i++) begin
            run_packet(vecs[i].s0v, vecs[i].s1v, vecs[i].expv, vecs[i].tag);
        end

        // Backpressure with ignored in_valid pulses during EMIT
        send_word(3'd4, 3'd2);
        send_word(3'd2, 3'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            s0_word  = 3'd7;
            s1_word  = 3'd7;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_word", int'(out_word), 6);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        check("bp_hold_word", int'(out_word), 6);
        out_ready = 1'b1;
        tick();
        check("bp_word1", int'(out_word), 3);
        check("bp_last1", int'(out_last), 1);
        tick();
        out_ready = 1'b0;
        check("bp_idle", int'(busy), 0);

        // Asynchronous reset mid-ACCUM
        send_word(3'd4, 3'd2);
        check("rstmid_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", int'(out_valid), 0);
        check("rstmid_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_packet(6'd20, 6'd10, 6'd30, "after_rst");

        // Flush during EMIT after word 0 handshake, then back-to-back packet
        send_word(3'd4, 3'd2);
        send_word(3'd2, 3'd1);
        out_ready = 1'b1;
        tick();
        check("fl_word1_pending", int'(out_word), 3);
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("fl_busy", int'(busy), 0);
        check("fl_in_ready", int'(in_ready), 1);
        check("fl_out_valid", int'(out_valid), 0);
        run_packet(6'd40, 6'd20, 6'd17, "after_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
